mem_responder: RTL

- Bus-side responder for the 8-bit CPU memory interface: 256x8 RAM plus two memory-mapped I/O registers.
- Answers read/write requests with a parameterised wait-state handshake on ready.
- Connects directly to the CPU bus pins: address, data_out→wdata, data_in←rdata, read, write, ready.

---
 rtl/mem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// 256x8 RAM plus two memory-mapped I/O registers answering the CPU bus with a
// wait-state handshake: one ready pulse per request, then a one-cycle GAP.
module mem_responder #(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [7:0] IO_OUT_ADDR = 8'hFF,
    parameter logic [7:0] IO_IN_ADDR  = 8'hFE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] wdata,
    input  logic       read,
    input  logic       write,
    output logic [7:0] rdata,
    output logic       ready,
    output logic [7:0] io_out,
    input  logic [7:0] io_in
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_e;

    localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d, wdat_q, wdat_d;
    logic            rd_q, rd_d, wr_q, wr_d;
    logic            ready_q, ready_d;
    logic [7:0]      rdata_q, rdata_d, io_out_q, io_out_d;
    logic [1:0][7:0] sync_q, sync_d;
    logic [7:0]      mem [256];

    logic            commit, ram_we, c_rd, c_wr;
    logic [7:0]      c_addr, c_wdat;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        io_out_d = io_out_q;
        sync_d   = {sync_q[0], io_in};
        commit   = 1'b0;
        c_addr   = addr_q;
        c_wdat   = wdat_q;
        c_rd     = rd_q;
        c_wr     = wr_q;

        case (state_q)
            IDLE: begin
                if (read || write) begin
                    addr_d = address;
                    wdat_d = wdata;
                    rd_d   = read;
                    wr_d   = write;
                    cnt_d  = WAIT_M1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: commit straight from the live bus.
                        state_d = ACK;
                        commit  = 1'b1;
                        c_addr  = address;
                        c_wdat  = wdata;
                        c_rd    = read;
                        c_wr    = write;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!read && !write) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (commit) begin
            if (c_rd && c_wr) begin
                rdata_d = 8'h00;
            end else if (c_wr) begin
                if (c_addr == IO_OUT_ADDR) io_out_d = c_wdat;
            end else if (c_rd) begin
                if (c_addr == IO_OUT_ADDR)     rdata_d = io_out_q;
                else if (c_addr == IO_IN_ADDR) rdata_d = sync_q[1];
                else                           rdata_d = mem[c_addr];
            end
        end

        ready_d = commit;
        // Gate with reset so a held request cannot write RAM while in reset.
        ram_we  = commit && c_wr && !c_rd && reset &&
                  (c_addr != IO_OUT_ADDR) && (c_addr != IO_IN_ADDR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 8'h00;
            wdat_q   <= 8'h00;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= 8'h00;
            io_out_q <= 8'h00;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            io_out_q <= io_out_d;
            sync_q   <= sync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[c_addr] <= c_wdat;
    end

    assign rdata  = rdata_q;
    assign ready  = ready_q;
    assign io_out = io_out_q;
endmodule
